// File: rtl/instr_fetch_decode.sv
// Single-issue fetch/decode front end for R-type instructions: fetches a word
// at pc, decodes the register/ALU fields, commits it, and halts on any illegal word.
//
// state | meaning
// IDLE  | post-reset settle cycle, no strobes
// REQ   | fetch request outstanding at pc, waiting for imem_ack
// VALID | legal instruction latched and presented; commits when stall=0
// HALT  | illegal word seen; frozen until reset
module instr_fetch_decode #(
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32,
    parameter logic [reg_data_width-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [reg_data_width-1:0] imem_addr,
    input  logic                      imem_ack,
    input  logic [reg_data_width-1:0] imem_rdata,
    input  logic                      stall,
    output logic [reg_addr_width-1:0] r_addr1,
    output logic [reg_addr_width-1:0] r_addr2,
    output logic [reg_addr_width-1:0] wr_addr,
    output logic                      reg_wr_en,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic                      instr_valid,
    output logic                      illegal_instr,
    output logic [reg_data_width-1:0] pc,
    output logic [reg_data_width-1:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [reg_data_width-1:0] pc_q, pc_d;
    logic [reg_data_width-1:0] count_q, count_d;
    // Opcode is consumed at fetch time, so only bits [31:7] are kept.
    logic [24:0]               instr_q, instr_d;
    logic                      rdata_legal;

    always_comb begin
        rdata_legal = 1'b0;
        if (imem_rdata[6:0] == 7'b0110011) begin
            if (imem_rdata[31:25] == 7'h00) begin
                rdata_legal = 1'b1;
            end else if (imem_rdata[31:25] == 7'h20) begin
                rdata_legal = (imem_rdata[14:12] == 3'b000) || (imem_rdata[14:12] == 3'b101);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        instr_d       = instr_q;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        reg_wr_en     = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata[31:7];
                    state_d = rdata_legal ? VALID : HALT;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    // x0 is hardwired, so a commit to it must not strobe the file.
                    reg_wr_en = (instr_q[4:0] != 5'd0);
                    pc_d      = pc_q + reg_data_width'(4);
                    count_d   = count_q + reg_data_width'(1);
                    state_d   = REQ;
                end
            end
            HALT: begin
                illegal_instr = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign retired_count = count_q;
    assign r_addr1       = reg_addr_width'(instr_q[12:8]);
    assign r_addr2       = reg_addr_width'(instr_q[17:13]);
    assign wr_addr       = reg_addr_width'(instr_q[4:0]);
    assign funct3        = instr_q[7:5];
    assign funct7        = instr_q[24:18];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [4:0]  r_addr1, r_addr2, wr_addr;
    logic        reg_wr_en, instr_valid, illegal_instr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc, retired_count;

    logic        rst_n_b = 1'b0;
    logic        imem_ack_b = 1'b1;
    logic [31:0] imem_rdata_b = 32'h003100B3;
    logic        stall_b = 1'b0;
    logic        imem_req_b;
    logic [31:0] imem_addr_b;
    logic [4:0]  r_addr1_b, r_addr2_b, wr_addr_b;
    logic        reg_wr_en_b, instr_valid_b, illegal_instr_b;
    logic [2:0]  funct3_b;
    logic [6:0]  funct7_b;
    logic [31:0] pc_b, retired_count_b;

    instr_fetch_decode dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .wr_addr(wr_addr),
        .reg_wr_en(reg_wr_en), .funct3(funct3), .funct7(funct7),
        .instr_valid(instr_valid), .illegal_instr(illegal_instr),
        .pc(pc), .retired_count(retired_count)
    );

    instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .stall(stall_b),
        .r_addr1(r_addr1_b), .r_addr2(r_addr2_b), .wr_addr(wr_addr_b),
        .reg_wr_en(reg_wr_en_b), .funct3(funct3_b), .funct7(funct7_b),
        .instr_valid(instr_valid_b), .illegal_instr(illegal_instr_b),
        .pc(pc_b), .retired_count(retired_count_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: where the fetch/execute loop is, plus architectural state.
    localparam int P_BOOT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_HOLD  = 2;
    localparam int P_DEAD  = 3;

    int          m_phase = P_BOOT;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_cnt   = '0;
    logic [31:0] m_word  = '0;

    function automatic bit is_rtype_legal(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] != 7'h33) return 1'b0;
        if (f7 == 7'h00) return 1'b1;
        return (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
    endfunction

    task automatic model_reset();
        m_phase = P_BOOT;
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_word  = 32'h0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("imem_req", imem_req, (m_phase == P_FETCH));
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("retired_count", retired_count, m_cnt);
            chk("instr_valid", instr_valid, (m_phase == P_HOLD));
            chk("illegal_instr", illegal_instr, (m_phase == P_DEAD));
            chk("reg_wr_en", reg_wr_en,
                (m_phase == P_HOLD) && !stall && (m_word[11:7] != 5'd0));
            chk("r_addr1", r_addr1, m_word[19:15]);
            chk("r_addr2", r_addr2, m_word[24:20]);
            chk("wr_addr", wr_addr, m_word[11:7]);
            chk("funct3", funct3, m_word[14:12]);
            chk("funct7", funct7, m_word[31:25]);
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                case (m_phase)
                    P_BOOT:  m_phase = P_FETCH;
                    P_FETCH: if (imem_ack) begin
                        m_word  = imem_rdata;
                        m_phase = is_rtype_legal(imem_rdata) ? P_HOLD : P_DEAD;
                    end
                    P_HOLD:  if (!stall) begin
                        m_pc    = m_pc + 32'd4;
                        m_cnt   = m_cnt + 32'd1;
                        m_phase = P_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_word();
        int          r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        r  = int'($urandom_range(0, 9));
        f3 = 3'($urandom_range(0, 7));
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        if (r == 9) return $urandom;
        if (r < 6) f7 = 7'h00;
        else if (r < 8) begin
            f7 = 7'h20;
            f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
        end else f7 = 7'h20;
        return {f7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3, rd, 7'h33};
    endfunction

    initial begin
        int halt_cycles;
        tick();
        tick();
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_cnt", retired_count, 32'h0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        chk("rst_illegal", illegal_instr, 1'b0);

        tick();
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        #2;
        chk("idle_no_req", imem_req, 1'b0);
        chk("wrap_idle_no_req", imem_req_b, 1'b0);

        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'h003100B3;
        #2;
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_first_addr", imem_addr_b, 32'hFFFF_FFFC);

        tick();
        imem_ack = 1'b0;
        #2;
        chk("add_valid", instr_valid, 1'b1);
        chk("add_rs1", r_addr1, 5'd2);
        chk("add_rs2", r_addr2, 5'd3);
        chk("add_rd", wr_addr, 5'd1);
        chk("add_we", reg_wr_en, 1'b1);

        tick();
        #2;
        chk("add_pc", pc, 32'h4);
        chk("add_cnt", retired_count, 32'h1);
        chk("model_pc_pin", m_pc, 32'h4);
        chk("wrap_next_addr", imem_addr_b, 32'h0);
        chk("wrap_cnt", retired_count_b, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = 32'h40208033;

        tick();
        imem_ack = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_we", reg_wr_en, 1'b0);
            chk("stall_pc", pc, 32'h4);
            chk("stall_cnt", retired_count, 32'h1);
            chk("sub_funct7", funct7, 7'h20);
            chk("sub_rs1", r_addr1, 5'd1);
            if (k < 2) tick();
        end
        tick();
        stall = 1'b0;
        #2;
        chk("sub_commit_we", reg_wr_en, 1'b0);
        chk("sub_commit_valid", instr_valid, 1'b1);

        tick();
        #2;
        chk("sub_pc", pc, 32'h8);
        chk("sub_cnt", retired_count, 32'h2);
        chk("model_cnt_pin", m_cnt, 32'h2);
        imem_ack = 1'b1;
        imem_rdata = 32'h00000013;

        for (int k = 0; k < 12; k++) begin
            tick();
            imem_ack = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            #2;
            chk("halt_illegal", illegal_instr, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_pc", pc, 32'h8);
        end

        tick();
        imem_ack = 1'b0;
        stall = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h003100B3;
        #2;
        chk("midreq_reset_drop", imem_req, 1'b0);
        tick();
        rst_n = 1'b1;
        #2;
        chk("rerelease_pc", pc, 32'h0);
        chk("rerelease_idle", imem_req, 1'b0);
        tick();
        imem_ack = 1'b0;
        #2;
        chk("rerelease_req", imem_req, 1'b1);
        tick();
        #2;
        chk("late_ack_ignored", instr_valid, 1'b0);

        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (illegal_instr) halt_cycles++;
            if (halt_cycles > 6 || $urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                halt_cycles = 0;
            end else begin
                rst_n = 1'b1;
            end
            imem_ack = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 9) < 3);
            imem_rdata = gen_word();
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
